aes_round_seq: RTL and testbench

Iterative AES-128 encryption sequencer: accepts one 128-bit plaintext block over a valid/ready handshake and runs one full AES round per clock through a registered state. Each round is SubBytes → ShiftRows → MixColumns → AddRoundKey, with MixColumns skipped in round 10. The ciphertext is presented over a valid/ready handshake. Round keys come from an external round-key store addressed by this block, so key expansion stays outside it.

---
 rtl/aes_round_seq.sv | 199 +++++++++++++++++++
 tb/tb_aes_round_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// aes_round_seq
// Iterative AES-128 encryption sequencer. A plaintext block is accepted over
// a valid/ready handshake and goes through round-0 AddRoundKey. The block
// then takes one full round per clock, ten rounds in total. The last round
// skips MixColumns. The ciphertext is held on out_data until the consumer
// accepts it.
//
// Round keys are not expanded here. The block drives rk_idx and expects the
// matching round key on rk_in combinationally in the same cycle.
//
// Optional feature: define AES_BLK_CNT_EN to add the blk_cnt port. It is a
// 32-bit count of completed output handshakes.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   plaintext offered
//   in_ready   block idle and able to accept plaintext
//   in_data    plaintext, byte i at bits [8*i+7:8*i]
//   rk_idx     round-key index requested (0..10)
//   rk_in      round key for rk_idx, same byte order
//   out_valid  ciphertext available
//   out_ready  consumer accepts ciphertext
//   out_data   ciphertext (state register), same byte order
//   blk_cnt    completed-block count (AES_BLK_CNT_EN only)
module aes_round_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // ---------------------------------------------------------------------
  // GF(2^8) helpers, using the field polynomial x^8 + x^4 + x^3 + x + 1
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // The S-box is the multiplicative inverse followed by the affine map.
  // The inverse is computed as a^254 = a^2 * a^4 * ... * a^128. This also
  // maps 0 to 0, as the S-box definition requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [3:0]   rnd_reg, rnd_next;

  // ---------------------------------------------------------------------
  // One-round combinational datapath
  // ---------------------------------------------------------------------
  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;
  logic [127:0] round_out;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sub
    assign sub_bytes[8*gi +: 8] = sbox(state_reg[8*gi +: 8]);
  end

  // Row r rotates left by r columns, so the byte landing in (row, col)
  // comes from (row, (col + row) mod 4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
    assign shift_rows[8*gi +: 8] = sub_bytes[8*SRC +: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shift_rows[32*gi      +: 8];
    assign a1 = shift_rows[32*gi + 8  +: 8];
    assign a2 = shift_rows[32*gi + 16 +: 8];
    assign a3 = shift_rows[32*gi + 24 +: 8];
    assign mix_cols[32*gi      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mix_cols[32*gi + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mix_cols[32*gi + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mix_cols[32*gi + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // The final round omits MixColumns.
  assign round_out = ((rnd_reg == LAST_RND) ? shift_rows : mix_cols) ^ rk_in;

  // ---------------------------------------------------------------------
  // FSM: register process
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      rnd_reg   <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state and output process
  // ---------------------------------------------------------------------
  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    rnd_next   = rnd_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rk_idx     = 4'd0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // rk_idx is 0 here, so rk_in is the round-0 key.
          state_next = in_data ^ rk_in;
          rnd_next   = 4'd1;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        rk_idx     = rnd_reg;
        state_next = round_out;
        if (rnd_reg == LAST_RND) begin
          fsm_next = DONE;
        end else begin
          rnd_next = rnd_reg + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign out_data = state_reg;

`ifdef AES_BLK_CNT_EN
  logic [31:0] blk_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_reg <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt_reg <= blk_cnt_reg + 32'd1;
    end
  end

  assign blk_cnt = blk_cnt_reg;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench for aes_round_seq.
// The reference model is a textbook AES-128. Its S-box table is generated
// from the multiply-by-3 / divide-by-3 field walk. The model does its own
// key expansion, and the resulting round keys also feed rk_in.
// Build with +define+AES_BLK_CNT_EN to exercise the block counter.
`timescale 1ns/1ps
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic [127:0] out_data;
`ifdef AES_BLK_CNT_EN
  logic [31:0]  blk_cnt;
  int           exp_blk = 0;
`endif

  logic [127:0] rk_tab [0:10];
  logic [7:0]   sbox_t [0:255];
  int           checks = 0;
  int           failures = 0;
  int           cur_blk = 0;

  always #5 clk = ~clk;

  assign rk_in = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : 128'h0;

  aes_round_seq #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AES_BLK_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Reverse byte order so FIPS text vectors (first byte written first)
  // map onto the byte-0-at-LSB packing used by the ports.
  function automatic logic [127:0] byte_rev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [7:0]   w [0:43][0:3];
    logic [7:0]   t [0:3];
    logic [7:0]   rcon;
    logic [127:0] rk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 4 == 0) begin
        t[0] = sbox_t[w[i-1][1]] ^ rcon;
        t[1] = sbox_t[w[i-1][2]];
        t[2] = sbox_t[w[i-1][3]];
        t[3] = sbox_t[w[i-1][0]];
        rcon = gmul(rcon, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) rk[8*(4*c+j) +: 8] = w[4*r+c][j];
    return rk;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [0:3][0:3];
    logic [7:0]   t [0:3][0:3];
    logic [7:0]   a [0:3];
    logic [127:0] rk;
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[8*(4*c+r) +: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][c]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) s[r][c] = t[r][(c+r)%4];
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[r][c];
            s[0][c] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
            s[1][c] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
            s[2][c] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
            s[3][c] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
          end
        end
      end
      rk = round_key(key, rnd);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ rk[8*(4*c+r) +: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[8*(4*c+r) +: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s blk=%0d got=%h expected=%h", name, cur_blk, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("ready_valid_exclusive", {127'd0, in_ready & out_valid}, 128'd0);
  endtask

  // Wait for in_ready and push one block. Check the rk_idx sequence, the
  // latency, busy-ignore behaviour and backpressure, then take the output.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input int hold, input bit busy);
    int waited;
    for (int i = 0; i <= 10; i++) rk_tab[i] = round_key(key, i);
    waited = 0;
    while (!in_ready && waited < 30) begin
      step();
      waited++;
    end
    check("in_ready_wait", {127'd0, in_ready}, 128'd1);
    if (!in_ready) return;
    // cycle T
    in_valid = 1'b1;
    in_data  = pt;
    check("rk_idx_accept", {124'd0, rk_idx}, 128'd0);
    step();
    in_valid = 1'b0;
    in_data  = ~pt;
    for (int k = 1; k <= 10; k++) begin
      check("rk_idx_run", {124'd0, rk_idx}, 128'(k));
      check("out_valid_run", {127'd0, out_valid}, 128'd0);
      check("in_ready_run", {127'd0, in_ready}, 128'd0);
      if (busy && k == 3) in_valid = 1'b1;
      step();
      in_valid = 1'b0;
    end
    // cycle T+11 onward: DONE, optionally held off by out_ready=0
    for (int h = 0; h <= hold; h++) begin
      check("out_valid_done", {127'd0, out_valid}, 128'd1);
      check("in_ready_done", {127'd0, in_ready}, 128'd0);
      check("rk_idx_done", {124'd0, rk_idx}, 128'd0);
      check("out_data", out_data, exp);
      if (busy && h == 0) in_valid = 1'b1;
      out_ready = (h == hold);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end
    check("in_ready_after", {127'd0, in_ready}, 128'd1);
    check("out_valid_after", {127'd0, out_valid}, 128'd0);
`ifdef AES_BLK_CNT_EN
    exp_blk++;
    check("blk_cnt", {96'd0, blk_cnt}, 128'(exp_blk));
`endif
    $display("blk %0d pt=%h exp=%h hold=%0d busy=%0d", cur_blk, pt, exp, hold, busy);
    cur_blk++;
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           hold;
    bit           busy;
  } vec_t;

  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

  initial begin
    vec_t         vecs [0:2];
    logic [127:0] rpt;
    logic [127:0] rkey;

    build_sbox();
    vecs[0] = '{C1_PT, C1_KEY, C1_CT, 0, 1'b0};
    vecs[1] = '{C1_PT, C1_KEY, C1_CT, 5, 1'b1};
    vecs[2] = '{byte_rev(128'h3243f6a8885a308d313198a2e0370734),
                byte_rev(128'h2b7e151628aed2a6abf7158809cf4f3c),
                byte_rev(128'h3925841d02dc09fbdc118597196a0b32), 2, 1'b0};
    for (int i = 0; i <= 10; i++) rk_tab[i] = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_out_data", out_data, 128'd0);
    check("reset_rk_idx", {124'd0, rk_idx}, 128'd0);
`ifdef AES_BLK_CNT_EN
    check("reset_blk_cnt", {96'd0, blk_cnt}, 128'd0);
`endif

    // known-answer vectors
    for (int i = 0; i < 3; i++)
      run_block(vecs[i].pt, vecs[i].key, vecs[i].ct, vecs[i].hold, vecs[i].busy);

    // random blocks against the model
    for (int i = 0; i < 6; i++) begin
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_block(rpt, rkey, model_encrypt(rpt, rkey), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    // reset in the middle of RUN
    for (int i = 0; i <= 10; i++) rk_tab[i] = round_key(C1_KEY, i);
    in_valid = 1'b1;
    in_data  = C1_PT;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_out_data", out_data, 128'd0);
`ifdef AES_BLK_CNT_EN
    exp_blk = 0;
    check("midrst_blk_cnt", {96'd0, blk_cnt}, 128'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      check("midrst_no_output", {127'd0, out_valid}, 128'd0);
      step();
    end

    // three back-to-back C.1 blocks after the aborted one
    for (int i = 0; i < 3; i++) run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0);

    // final reset clears the counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("final_in_ready", {127'd0, in_ready}, 128'd1);
`ifdef AES_BLK_CNT_EN
    check("final_blk_cnt", {96'd0, blk_cnt}, 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
